// File: rtl/if_stage.sv
// Instruction fetch stage: one outstanding request, ISSUE/WAIT/FULL sequencing, redirect flush.
// Optional misaligned-redirect fault detection is compiled in with `define IF_ALIGN_CHECK_EN.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC_out,
  output logic [31:0] Instr_out,
  output logic        valid_out,
  output logic        addr_err
);

  typedef enum logic [1:0] {
    ISSUE = 2'd0,
    WAIT  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic        kill;
  logic [31:0] target;
  logic        target_bad;

`ifdef IF_ALIGN_CHECK_EN
  assign target     = redirect_pc;
  assign target_bad = |redirect_pc[1:0];
`else
  logic unused_target_lsbs;
  assign target             = {redirect_pc[31:2], 2'b00};
  assign target_bad         = 1'b0;
  assign unused_target_lsbs = ^redirect_pc[1:0];
`endif

  // The request is combinational so a redirect arriving in ISSUE suppresses it in the same cycle.
  assign imem_req  = !rst && (state == ISSUE) && !redirect && !addr_err;
  assign imem_addr = pc;

  // NOTE: all state here is updated with non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ISSUE;
      pc        <= RESET_PC;
      kill      <= 1'b0;
      PC_out    <= 32'h0000_0000;
      Instr_out <= 32'h0000_0000;
      valid_out <= 1'b0;
      addr_err  <= 1'b0;
    end else if (redirect) begin
      pc        <= target;
      valid_out <= 1'b0;
      addr_err  <= target_bad;
      // A request still in flight must have its response swallowed when it finally arrives.
      if (state == WAIT && !imem_rvalid) begin
        kill <= 1'b1;
      end else begin
        kill  <= 1'b0;
        state <= ISSUE;
      end
    end else begin
      unique case (state)
        ISSUE: begin
          if (imem_req) state <= WAIT;
        end
        WAIT: begin
          if (imem_rvalid) begin
            if (kill) begin
              kill  <= 1'b0;
              state <= ISSUE;
            end else begin
              PC_out    <= pc;
              Instr_out <= imem_rdata;
              valid_out <= 1'b1;
              pc        <= pc + 32'd4;
              state     <= FULL;
            end
          end
        end
        FULL: begin
          if (!stall) begin
            valid_out <= 1'b0;
            state     <= ISSUE;
          end
        end
        default: state <= ISSUE;
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios followed by randomized traffic,
// checked against a fetch-stream model (expected next PC, one request in flight, held outputs).
module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] WRAP_PC  = 32'hFFFF_FFFC;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] pc_out;
  logic [31:0] instr_out;
  logic        valid_out;
  logic        addr_err;

  logic        w_req;
  logic [31:0] w_addr;
  logic        w_rvalid;
  logic [31:0] w_rdata;
  logic [31:0] w_pc;
  logic [31:0] w_instr;
  logic        w_valid;
  logic        w_err;

  if_stage #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .PC_out(pc_out), .Instr_out(instr_out),
    .valid_out(valid_out), .addr_err(addr_err)
  );

  if_stage #(.RESET_PC(WRAP_PC)) u_wrap (
    .clk(clk), .rst(rst), .stall(1'b0), .redirect(1'b0), .redirect_pc(32'h0000_0000),
    .imem_req(w_req), .imem_addr(w_addr), .imem_rvalid(w_rvalid),
    .imem_rdata(w_rdata), .PC_out(w_pc), .Instr_out(w_instr),
    .valid_out(w_valid), .addr_err(w_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [31:0] exp_pc;
  logic        err_mode;
  logic        pend;
  int          pend_cnt;
  logic [31:0] pend_addr;
  bit          echo;
  bit          spur_en;
  int          lat_fixed;
  int          ndeliv;
  int          idle;
  logic        p_valid, p_stall, p_redirect;
  logic [31:0] p_pc, p_instr;
  logic        s_valid, s_err, s_req;
  logic [31:0] s_pc, s_instr, s_addr;
  logic        w_pend;
  logic [31:0] w_pend_addr;
  logic [31:0] w_log[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] data_fn(input logic [31:0] a);
    return echo ? a : ({a[7:0], a[31:8]} ^ 32'h1357_9BDF);
  endfunction

  function automatic logic [31:0] fix_target(input logic [31:0] a);
`ifdef IF_ALIGN_CHECK_EN
    return a;
`else
    return a & 32'hFFFF_FFFC;
`endif
  endfunction

  function automatic logic misaligned(input logic [31:0] a);
`ifdef IF_ALIGN_CHECK_EN
    return a[1:0] != 2'b00;
`else
    return (a[1:0] != 2'b00) && 1'b0;
`endif
  endfunction

  // One clock cycle, entered and left at a falling edge.
  task automatic cyc(input logic st, input logic rd, input logic [31:0] rp);
    logic resp_now;
    logic exp_req;
    s_valid = valid_out;
    s_pc    = pc_out;
    s_instr = instr_out;
    s_err   = addr_err;
    chk("addr_err", s_err, err_mode);
    if (p_redirect) begin
      chk("valid_after_redirect", s_valid, 1'b0);
    end else if (p_valid) begin
      chk("hold_or_consume", s_valid, p_stall);
      if (s_valid) begin
        chk("held_pc", s_pc, p_pc);
        chk("held_instr", s_instr, p_instr);
      end
    end else if (s_valid) begin
      chk("deliver_pc", s_pc, exp_pc);
      chk("deliver_instr", s_instr, data_fn(exp_pc));
      exp_pc = exp_pc + 32'd4;
      ndeliv++;
      idle = 0;
    end
    if (w_valid) chk("wrap_instr", w_instr, w_pc);

    // NOTE: stimulus is driven with blocking assignments at the falling edge so it is
    // stable well before the DUT samples it.
    stall       = st;
    redirect    = rd;
    redirect_pc = rp;
    resp_now    = 1'b0;
    if (pend) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        pend     = 1'b0;
        resp_now = 1'b1;
      end
    end
    if (resp_now) begin
      imem_rvalid = 1'b1;
      imem_rdata  = data_fn(pend_addr);
    end else if (!pend && spur_en && $urandom_range(9) == 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = $urandom;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    w_rvalid = w_pend;
    w_rdata  = w_pend_addr;
    w_pend   = 1'b0;

    #1;
    s_req   = imem_req;
    s_addr  = imem_addr;
    exp_req = !rd && !err_mode && !s_valid && !pend && !resp_now;
    chk("imem_req", s_req, exp_req);
    if (s_req) begin
      chk("imem_addr", s_addr, exp_pc);
      pend      = 1'b1;
      pend_addr = s_addr;
      pend_cnt  = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(3, 1));
    end
    if (w_req) begin
      w_pend      = 1'b1;
      w_pend_addr = w_addr;
      if (w_log.size() < 2) w_log.push_back(w_addr);
    end

    if (rd) begin
      exp_pc   = fix_target(rp);
      err_mode = misaligned(rp);
    end
    p_valid    = s_valid;
    p_stall    = st;
    p_redirect = rd;
    p_pc       = s_pc;
    p_instr    = s_instr;
    idle++;
    if (err_mode || (s_valid && st)) idle = 0;
    if (idle > 100) begin
      chk("progress_watchdog", idle, 0);
      idle = 0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst         = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    imem_rvalid = 1'b0;
    w_rvalid    = 1'b0;
    pend        = 1'b0;
    w_pend      = 1'b0;
    #1;
    chk("rst_valid", valid_out, 1'b0);
    chk("rst_pc_out", pc_out, 32'h0);
    chk("rst_instr_out", instr_out, 32'h0);
    chk("rst_addr_err", addr_err, 1'b0);
    chk("rst_imem_req", imem_req, 1'b0);
    chk("rst_imem_addr", imem_addr, RESET_PC);
    repeat (n) @(negedge clk);
    rst        = 1'b0;
    exp_pc     = RESET_PC;
    err_mode   = 1'b0;
    p_valid    = 1'b0;
    p_stall    = 1'b0;
    p_redirect = 1'b0;
    idle       = 0;
  endtask

  task automatic wait_delivery(input int bound);
    int start;
    int i;
    start = ndeliv;
    i     = 0;
    cyc(1'b0, 1'b0, 32'h0);
    while (ndeliv == start && i < bound) begin
      cyc(1'b1, 1'b0, 32'h0);
      i++;
    end
    chk("delivery_timeout", ndeliv != start, 1'b1);
  endtask

  task automatic wait_req(input int bound);
    int i;
    i = 0;
    do begin
      cyc(1'b0, 1'b0, 32'h0);
      i++;
    end while (!s_req && i < bound);
    chk("req_timeout", s_req, 1'b1);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    imem_rvalid = 1'b0; imem_rdata = 32'h0; w_rvalid = 1'b0; w_rdata = 32'h0;
    echo = 1'b1; spur_en = 1'b0; lat_fixed = 1; ndeliv = 0;
    @(negedge clk);
    do_reset(2);

    // Sequential fetch with 1-cycle echo memory, stall applied once PC 8 lands
    for (int k = 0; k < 9; k++) begin
      cyc(k == 8, 1'b0, 32'h0);
      if (k == 0) begin
        chk("first_req", s_req, 1'b1);
        chk("first_addr", s_addr, RESET_PC);
      end
      chk("valid_pattern", s_valid, (k % 3) == 2);
    end
    chk("pc8_held", s_pc, 32'h8);
    chk("wrap_req_count", w_log.size(), 2);
    if (w_log.size() == 2) begin
      chk("wrap_first_addr", w_log[0], WRAP_PC);
      chk("wrap_second_addr", w_log[1], 32'h0);
    end
    chk("wrap_err", w_err, 1'b0);
    echo = 1'b0;

    repeat (4) begin
      cyc(1'b1, 1'b0, 32'h0);
      chk("stall_pc", s_pc, 32'h8);
      chk("stall_no_req", s_req, 1'b0);
    end
    cyc(1'b0, 1'b0, 32'h0);
    lat_fixed = 4;
    cyc(1'b0, 1'b0, 32'h0);
    chk("post_stall_req", s_req, 1'b1);
    chk("post_stall_addr", s_addr, 32'hC);

    // Redirect while waiting; the stale response lands three cycles later
    cyc(1'b0, 1'b1, 32'h100);
    lat_fixed = 1;
    cyc(1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 32'h0);
    chk("killed_resp_no_req", s_req, 1'b0);
    cyc(1'b0, 1'b0, 32'h0);
    chk("redirect_req", s_req, 1'b1);
    chk("redirect_addr", s_addr, 32'h100);
    wait_delivery(20);
    chk("redirect_delivered", s_pc, 32'h100);

    // Redirect together with stall while FULL
    cyc(1'b1, 1'b1, 32'h400);
    cyc(1'b0, 1'b0, 32'h0);
    chk("full_redirect_valid", s_valid, 1'b0);
    chk("full_redirect_req", s_req, 1'b1);
    chk("full_redirect_addr", s_addr, 32'h400);

    // Redirect in ISSUE suppresses that cycle's request
    cyc(1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 32'h800);
    chk("issue_redirect_no_req", s_req, 1'b0);
    cyc(1'b0, 1'b0, 32'h0);
    chk("issue_redirect_addr", s_addr, 32'h800);

    // Redirect in the same cycle as the response
    cyc(1'b0, 1'b1, 32'h900);
    chk("same_cycle_no_req", s_req, 1'b0);
    cyc(1'b0, 1'b0, 32'h0);
    chk("same_cycle_valid", s_valid, 1'b0);
    chk("same_cycle_addr", s_addr, 32'h900);
    wait_delivery(20);

    // Address wrap at the top of the space
    cyc(1'b1, 1'b1, 32'hFFFF_FFF8);
    wait_delivery(20);
    chk("wrap_pc0", s_pc, 32'hFFFF_FFF8);
    wait_delivery(20);
    chk("wrap_pc1", s_pc, 32'hFFFF_FFFC);
    wait_delivery(20);
    chk("wrap_pc2", s_pc, 32'h0);

    // Reset while a request is outstanding
    lat_fixed = 3;
    wait_req(20);
    cyc(1'b0, 1'b0, 32'h0);
    do_reset(1);
    lat_fixed = 0;
    cyc(1'b0, 1'b0, 32'h0);
    chk("mid_wait_reset_req", s_req, 1'b1);
    chk("mid_wait_reset_addr", s_addr, RESET_PC);
    wait_delivery(20);
    chk("mid_wait_reset_pc", s_pc, RESET_PC);

    // Misaligned redirect target
    cyc(1'b0, 1'b1, 32'h102);
`ifdef IF_ALIGN_CHECK_EN
    repeat (4) begin
      cyc(1'b0, 1'b0, 32'h0);
      chk("misalign_err", s_err, 1'b1);
      chk("misalign_no_req", s_req, 1'b0);
    end
    cyc(1'b0, 1'b1, 32'h200);
    cyc(1'b0, 1'b0, 32'h0);
    chk("realign_err", s_err, 1'b0);
    chk("realign_req", s_req, 1'b1);
    chk("realign_addr", s_addr, 32'h200);
    wait_delivery(20);
    chk("realign_pc", s_pc, 32'h200);
`else
    cyc(1'b0, 1'b0, 32'h0);
    chk("lsb_forced_err", s_err, 1'b0);
    chk("lsb_forced_req", s_req, 1'b1);
    chk("lsb_forced_addr", s_addr, 32'h100);
    wait_delivery(20);
    chk("lsb_forced_pc", s_pc, 32'h100);
`endif

    // Randomized traffic
    begin
      int start;
      logic [31:0] rp;
      start   = ndeliv;
      spur_en = 1'b1;
      for (int i = 0; i < 600; i++) begin
        rp = ($urandom & 32'h000F_FFFC) | (($urandom_range(3) == 0) ? 32'($urandom_range(3, 1)) : 32'h0);
        if ($urandom_range(7) == 0) rp = rp | 32'hFFFF_FF00;
        cyc($urandom_range(9) < 3, $urandom_range(15) == 0, rp);
      end
      chk("random_progress", (ndeliv - start) > 20, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 Port: clk  input  1  rising-edge clock.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: stall  input  1  downstream IF/ID hold; current output not consumed this cycle.
REQ-005 Port: redirect  input  1  branch/jump taken; replaces fetch PC.
REQ-006 Port: redirect_pc  input  32  target address, sampled when redirect=1.
REQ-007 Port: imem_req  output  1  one-cycle request pulse to instruction memory.
REQ-008 Port: imem_addr  output  32  word address of the request; valid when imem_req=1.
REQ-009 Port: imem_rvalid  input  1  response strobe; exactly one per request, 1 or more cycles after it.
REQ-010 Port: imem_rdata  input  32  instruction word, valid with imem_rvalid.
REQ-011 Port: PC_out  output  32  address of the delivered instruction, registered.
REQ-012 Port: Instr_out  output  32  delivered instruction, registered.
REQ-013 Port: valid_out  output  1  PC_out/Instr_out hold a live instruction.
REQ-014 Port: addr_err  output  1  misaligned redirect fault (see Configuration).

Function
REQ-015 FSM states ISSUE, WAIT, FULL; at most one memory request outstanding.
REQ-016 ISSUE: imem_req = !redirect, imem_addr = pc; next state WAIT if imem_req, else ISSUE.
REQ-017 WAIT, imem_rvalid=0: hold; pc and outputs unchanged.
REQ-018 WAIT, imem_rvalid=1, kill=0: PC_out<=pc, Instr_out<=imem_rdata, valid_out<=1, pc<=pc+4, next FULL.
REQ-019 WAIT, imem_rvalid=1, kill=1: response discarded, kill<=0, outputs unchanged, next ISSUE.
REQ-020 FULL: stall=1 holds all outputs; stall=0 means consumed this cycle, valid_out<=0, next ISSUE.
REQ-021 Steady-state throughput with 1-cycle memory: one instruction per 3 cycles; in-order, no drops, no duplicates.
REQ-022 redirect=1 (any state) has priority over stall and over normal sequencing: pc<=redirect_pc, valid_out<=0 next edge.
REQ-023 redirect in ISSUE: no request that cycle; next cycle ISSUE at redirect_pc.
REQ-024 redirect in WAIT without rvalid: kill<=1, stay WAIT; with rvalid same cycle: discard response, next ISSUE.
REQ-025 redirect in FULL: flush output, next ISSUE.
REQ-026 pc+4 is modulo 2^32: 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-027 imem_rvalid outside WAIT is ignored.

Reset
REQ-028 rst=1 asynchronously: pc=RESET_PC, state=ISSUE, kill=0, valid_out=0, PC_out=0, Instr_out=0, addr_err=0, imem_req=0.
REQ-029 First request (imem_addr=RESET_PC) issued in the first clock cycle after rst falls.
REQ-030 Reset mid-WAIT abandons the request; instruction memory shares rst and drops it too.

Configuration
REQ-031 Macro IF_ALIGN_CHECK_EN defined: redirect with redirect_pc[1:0]!=0 sets addr_err=1, valid_out=0, kill set if WAIT, no further requests until an aligned redirect (clears addr_err) or reset.
REQ-032 IF_ALIGN_CHECK_EN undefined: redirect_pc[1:0] forced to 2'b00, addr_err tied 0.

Verification
REQ-033 Reset release, 1-cycle memory returning addr as data, stall=0 -> PC_out 0,4,8 with Instr_out equal, valid_out pulses every 3rd cycle.
REQ-034 stall=1 for 5 cycles while FULL at PC 8 -> outputs stable, imem_req=0; stall drops -> next request addr 12.
REQ-035 redirect to 32'h0000_0100 in WAIT, response 3 cycles later -> response dropped, next imem_addr=0x100, delivered PC_out=0x100.
REQ-036 RESET_PC=32'hFFFF_FFFC -> second request addr 32'h0000_0000.
REQ-037 redirect and stall together while FULL -> valid_out=0 next cycle, next request at redirect_pc.
REQ-038 With IF_ALIGN_CHECK_EN, redirect_pc=0x102 -> addr_err=1, no imem_req; redirect to 0x200 -> addr_err=0, fetch 0x200.
